// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display with one shared BCD decoder.
//
// Each digit slot is DIV cycles long. The first GUARD cycles are blank, with
// all anodes high. The remaining cycles drive the digit's anode low, unless the
// nibble is not a BCD digit (>9) or the digit is a suppressed leading zero.
//
// New values are double-buffered in a shadow register. They are committed to
// the display register on the last cycle of a frame, so a frame never mixes
// old and new digits.
//
// Optional build macro:
//   SEG7_LZB_EN - leading-zero blanking. Digits above the most significant
//                 nonzero digit stay dark. Digit 0 is always shown.
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 16
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iEn,
  input  logic [4*DIGITS-1:0]   iValue,
  input  logic                  iLoad,
  output logic                  oPending,
  output logic [3:0]            oNibble,
  output logic [DIGITS-1:0]     oAn,
  output logic                  oFrame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_GLAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // Select the BCD nibble of digit k from a packed multi-digit value.
  function automatic logic [3:0] digit_of(input logic [4*DIGITS-1:0] v,
                                          input logic [IW-1:0] k);
    return v[4*int'(k) +: 4];
  endfunction

`ifdef SEG7_LZB_EN
  // Index of the most significant nonzero digit. Returns 0 when the value is all zero.
  function automatic logic [IW-1:0] lead_idx(input logic [4*DIGITS-1:0] v);
    logic [IW-1:0] r;
    r = IDX_ZERO;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] != 4'd0) begin
        r = IW'(k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction
`endif

  logic [1:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0]    disp_q, disp_d;
  logic [4*DIGITS-1:0]    shadow_q, shadow_d;
  logic                   pend_q, pend_d;
  logic [3:0]             nib_q, nib_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   frame_q, frame_d;
  logic                   frame_now_s;
  logic                   lzb_ok_s;
  logic                   show_s;

  // Scan sequencer: idle, then guard and show phases for each digit slot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!iEn) begin
      state_d = ST_IDLE;
      idx_d   = IDX_ZERO;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_GUARD;
          idx_d   = IDX_ZERO;
          cnt_d   = CNT_ZERO;
        end
        ST_GUARD: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_GLAST) begin
            state_d = ST_SHOW;
          end else begin
            state_d = ST_GUARD;
          end
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = ST_GUARD;
            if (idx_q == IDX_LAST) begin
              idx_d = IDX_ZERO;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = IDX_ZERO;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Load handshake. An idle display or a frame-boundary load writes straight
  // through. Any other load parks the value in the shadow until the boundary.
  always_comb begin
    disp_d      = disp_q;
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    frame_now_s = (state_q == ST_SHOW) && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
    if (iLoad) begin
      if (state_q == ST_IDLE) begin
        disp_d = iValue;
        pend_d = 1'b0;
      end else if (frame_now_s) begin
        disp_d = iValue;
        pend_d = 1'b0;
      end else begin
        shadow_d = iValue;
        pend_d   = 1'b1;
      end
    end else if (frame_now_s && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end else begin
      disp_d = disp_q;
    end
  end

  // Output decode from next-state values, so the registered outputs line up with the state.
  always_comb begin
    nib_d = digit_of(disp_d, idx_d);
`ifdef SEG7_LZB_EN
    lzb_ok_s = (idx_d <= lead_idx(disp_d));
`else
    lzb_ok_s = 1'b1;
`endif
    show_s = (state_d == ST_SHOW) && (nib_d <= 4'd9) && lzb_ok_s;
    an_d   = {DIGITS{1'b1}};
    for (int k = 0; k < DIGITS; k++) begin
      if (show_s && (idx_d == IW'(k))) begin
        an_d[k] = 1'b0;
      end else begin
        an_d[k] = 1'b1;
      end
    end
    frame_d = (state_d == ST_SHOW) && (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
  end

  // State, buffer and output registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_ZERO;
      cnt_q    <= CNT_ZERO;
      disp_q   <= {(4*DIGITS){1'b0}};
      shadow_q <= {(4*DIGITS){1'b0}};
      pend_q   <= 1'b0;
      nib_q    <= 4'd0;
      an_q     <= {DIGITS{1'b1}};
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      nib_q    <= nib_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign oPending = pend_q;
  assign oNibble  = nib_q;
  assign oAn      = an_q;
  assign oFrame   = frame_q;

endmodule
